// File: rtl/e_core_boot_pkg.sv
// Shared types and constants for the e_core boot loader.
// boot_state_e : boot sequencer states
// CSR_*_OFF    : byte offsets of the core CSRs from CSR_BASE
// AXI_*        : AXI4 response and burst encodings
package e_core_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WR,
    ST_WAIT_B,
    ST_PC,
    ST_CTRL,
    ST_DONE,
    ST_ERR
  } boot_state_e;

  localparam logic [31:0] CSR_CTRL_OFF = 32'h0000_0000;
  localparam logic [31:0] CSR_PC_OFF   = 32'h0000_0004;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

endpackage

// File: rtl/e_core_boot_axi_wr.sv
// Single-beat AXI4 write engine: one outstanding write at a time.
// req      : level, held while the owner wants a write issued; addr/data/strb
//            must stay stable while req is high
// abort    : drops a pending B phase (bready falls next cycle)
// data_done: pulse, AW and W both complete this cycle
// done     : pulse, B accepted this cycle; resp carries bresp
// AW/W/B   : AXI4 master write channels (ID 0, len 0, INCR, full-width size)
module e_core_boot_axi_wr
  import e_core_boot_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned ID_W   = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  abort,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     data,
  input  logic [DATA_W/8-1:0]   strb,
  output logic                  data_done,
  output logic                  done,
  output logic [1:0]            resp,
  output logic                  awvalid_o,
  input  logic                  awready_i,
  output logic [ADDR_W-1:0]     awaddr_o,
  output logic [ID_W-1:0]       awid_o,
  output logic [7:0]            awlen_o,
  output logic [2:0]            awsize_o,
  output logic [1:0]            awburst_o,
  output logic                  wvalid_o,
  input  logic                  wready_i,
  output logic [DATA_W-1:0]     wdata_o,
  output logic [DATA_W/8-1:0]   wstrb_o,
  output logic                  wlast_o,
  input  logic                  bvalid_i,
  output logic                  bready_o,
  input  logic [1:0]            bresp_i
);

  localparam logic [2:0] AW_SIZE = 3'($clog2(DATA_W / 8));

  logic aw_ok;
  logic w_ok;
  logic b_pend;
  logic aw_hs;
  logic w_hs;
  logic issue;

  // Each channel drops independently once its own handshake is done.
  assign issue     = req & ~b_pend;
  assign awvalid_o = issue & ~aw_ok;
  assign wvalid_o  = issue & ~w_ok;
  assign aw_hs     = awvalid_o & awready_i;
  assign w_hs      = wvalid_o & wready_i;
  assign data_done = issue & (aw_ok | aw_hs) & (w_ok | w_hs);

  assign bready_o  = b_pend;
  assign done      = b_pend & bvalid_i;
  assign resp      = bresp_i;

  assign awaddr_o  = addr;
  assign awid_o    = '0;
  assign awlen_o   = '0;
  assign awsize_o  = AW_SIZE;
  assign awburst_o = AXI_BURST_INCR;
  assign wdata_o   = data;
  assign wstrb_o   = strb;
  assign wlast_o   = 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aw_ok  <= 1'b0;
      w_ok   <= 1'b0;
      b_pend <= 1'b0;
    end else if (abort) begin
      aw_ok  <= 1'b0;
      w_ok   <= 1'b0;
      b_pend <= 1'b0;
    end else if (data_done) begin
      aw_ok  <= 1'b0;
      w_ok   <= 1'b0;
      b_pend <= 1'b1;
    end else begin
      if (aw_hs) aw_ok <= 1'b1;
      if (w_hs)  w_ok  <= 1'b1;
      if (done)  b_pend <= 1'b0;
    end
  end

endmodule

// File: rtl/e_core_boot_loader.sv
// Boot loader feeding the e_core_ss AXI slave port: writes each image word as a
// single-beat AXI4 write, then writes the start PC (CSR_BASE+4) and the run bit
// (CSR_BASE+0).
// Ports: io_aclk/io_aresetn (sync active-low), start_i/start_pc_i boot request,
//        img_* image stream (valid/ready), aw*/w*/b* AXI4 write master,
//        busy_o, done_o (sticky), err_o (sticky), word_cnt_o (OKAY image words).
// Build option: define E_CORE_BOOT_TIMEOUT_EN to abort a write whose B response
//        does not arrive within TMO_CYC cycles.
module e_core_boot_loader
  import e_core_boot_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned ID_W     = 6,
  parameter logic [31:0] CSR_BASE = 32'h0003_0000,
  parameter int unsigned TMO_CYC  = 1024
) (
  input  logic                  io_aclk,
  input  logic                  io_aresetn,
  input  logic                  start_i,
  input  logic [ADDR_W-1:0]     start_pc_i,
  input  logic                  img_valid_i,
  output logic                  img_ready_o,
  input  logic [ADDR_W-1:0]     img_addr_i,
  input  logic [DATA_W-1:0]     img_data_i,
  input  logic                  img_last_i,
  output logic                  awvalid_o,
  input  logic                  awready_i,
  output logic [ADDR_W-1:0]     awaddr_o,
  output logic [ID_W-1:0]       awid_o,
  output logic [7:0]            awlen_o,
  output logic [2:0]            awsize_o,
  output logic [1:0]            awburst_o,
  output logic                  wvalid_o,
  input  logic                  wready_i,
  output logic [DATA_W-1:0]     wdata_o,
  output logic [DATA_W/8-1:0]   wstrb_o,
  output logic                  wlast_o,
  input  logic                  bvalid_i,
  output logic                  bready_o,
  input  logic [1:0]            bresp_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [31:0]           word_cnt_o
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam logic [ADDR_W-1:0] ALIGN_MASK   = ~ADDR_W'(STRB_W - 1);
  localparam logic [ADDR_W-1:0] CSR_PC_ADDR  = ADDR_W'(CSR_BASE + CSR_PC_OFF);
  localparam logic [ADDR_W-1:0] CSR_CTL_ADDR = ADDR_W'(CSR_BASE + CSR_CTRL_OFF);

  boot_state_e state_q, state_d;

  logic [ADDR_W-1:0] img_addr_q;
  logic [DATA_W-1:0] img_data_q;
  logic              img_last_q;
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       word_cnt_q;
  logic              done_q;
  logic              err_q;

  logic              wr_req;
  logic              wr_abort;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic              wr_data_done;
  logic              wr_done;
  logic [1:0]        wr_resp;
  logic              resp_ok;
  logic              tmo_hit;
  logic              start_ok;
  logic              img_accept;

  // A 32-bit CSR value sits in the 32-bit lane selected by the byte address.
  function automatic logic [DATA_W-1:0] csr_data(input logic [ADDR_W-1:0] a,
                                                 input logic [31:0] v);
    int unsigned lane;
    lane = 32'(a[OFF_W-1:0]) >> 2;
    return DATA_W'(v) << (32 * lane);
  endfunction

  function automatic logic [STRB_W-1:0] csr_strb(input logic [ADDR_W-1:0] a);
    int unsigned lane;
    lane = 32'(a[OFF_W-1:0]) >> 2;
    return STRB_W'(4'hF) << (4 * lane);
  endfunction

  assign start_ok   = start_i & (state_q inside {ST_IDLE, ST_DONE, ST_ERR});
  assign img_accept = (state_q == ST_LOAD) & img_valid_i;
  assign resp_ok    = (wr_resp == AXI_RESP_OKAY);

  assign img_ready_o = (state_q == ST_LOAD);
  assign busy_o      = ~(state_q inside {ST_IDLE, ST_DONE, ST_ERR});
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign word_cnt_o  = word_cnt_q;

  assign wr_req   = state_q inside {ST_WR, ST_PC, ST_CTRL};
  assign wr_abort = tmo_hit;

  always_comb begin
    wr_addr = img_addr_q;
    wr_data = img_data_q;
    wr_strb = '1;
    case (state_q)
      ST_PC: begin
        wr_addr = CSR_PC_ADDR;
        wr_data = csr_data(CSR_PC_ADDR, 32'(pc_q));
        wr_strb = csr_strb(CSR_PC_ADDR);
      end
      ST_CTRL: begin
        wr_addr = CSR_CTL_ADDR;
        wr_data = csr_data(CSR_CTL_ADDR, 32'd1);
        wr_strb = csr_strb(CSR_CTL_ADDR);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR:
        if (start_i) state_d = ST_LOAD;
      ST_LOAD:
        if (img_valid_i) state_d = ST_WR;
      ST_WR:
        if (wr_data_done) state_d = ST_WAIT_B;
      ST_WAIT_B:
        if (wr_done)      state_d = !resp_ok ? ST_ERR : (img_last_q ? ST_PC : ST_LOAD);
        else if (tmo_hit) state_d = ST_ERR;
      ST_PC:
        if (wr_done)      state_d = resp_ok ? ST_CTRL : ST_ERR;
        else if (tmo_hit) state_d = ST_ERR;
      ST_CTRL:
        if (wr_done)      state_d = resp_ok ? ST_DONE : ST_ERR;
        else if (tmo_hit) state_d = ST_ERR;
      default:
        state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge io_aclk) begin
    if (!io_aresetn) begin
      state_q    <= ST_IDLE;
      img_addr_q <= '0;
      img_data_q <= '0;
      img_last_q <= 1'b0;
      pc_q       <= '0;
      word_cnt_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        pc_q       <= start_pc_i;
        word_cnt_q <= '0;
        done_q     <= 1'b0;
        err_q      <= 1'b0;
      end
      if (img_accept) begin
        img_addr_q <= img_addr_i & ALIGN_MASK;
        img_data_q <= img_data_i;
        img_last_q <= img_last_i;
      end
      if ((state_q == ST_WAIT_B) && wr_done && resp_ok)
        word_cnt_q <= word_cnt_q + 32'd1;
      if ((state_q == ST_CTRL) && wr_done && resp_ok)
        done_q <= 1'b1;
      if ((wr_done && !resp_ok) || tmo_hit)
        err_q <= 1'b1;
    end
  end

`ifdef E_CORE_BOOT_TIMEOUT_EN
  // Counts cycles spent waiting for B; bready_o marks the B phase of any write.
  logic [31:0] tmo_cnt_q;

  assign tmo_hit = bready_o & ~bvalid_i & (tmo_cnt_q == 32'(TMO_CYC - 1));

  always_ff @(posedge io_aclk) begin
    if (!io_aresetn || !bready_o) tmo_cnt_q <= '0;
    else if (!bvalid_i)           tmo_cnt_q <= tmo_cnt_q + 32'd1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  e_core_boot_axi_wr #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .ID_W  (ID_W)
  ) u_axi_wr (
    .clk       (io_aclk),
    .rst_n     (io_aresetn),
    .req       (wr_req),
    .abort     (wr_abort),
    .addr      (wr_addr),
    .data      (wr_data),
    .strb      (wr_strb),
    .data_done (wr_data_done),
    .done      (wr_done),
    .resp      (wr_resp),
    .awvalid_o (awvalid_o),
    .awready_i (awready_i),
    .awaddr_o  (awaddr_o),
    .awid_o    (awid_o),
    .awlen_o   (awlen_o),
    .awsize_o  (awsize_o),
    .awburst_o (awburst_o),
    .wvalid_o  (wvalid_o),
    .wready_i  (wready_i),
    .wdata_o   (wdata_o),
    .wstrb_o   (wstrb_o),
    .wlast_o   (wlast_o),
    .bvalid_i  (bvalid_i),
    .bready_o  (bready_o),
    .bresp_i   (bresp_i)
  );

endmodule

// File: tb/tb_e_core_boot_loader.sv
// Self-checking bench for e_core_boot_loader (ADDR_W=32, DATA_W=128, TMO_CYC=16).
// Table-driven image boots plus hand-written error, reset, start-ignore and
// B-timeout sequences. Build with E_CORE_BOOT_TIMEOUT_EN to exercise the timeout.
module tb_e_core_boot_loader;

  logic          clk = 1'b0;
  logic          aresetn;
  logic          start_i;
  logic [31:0]   start_pc_i;
  logic          img_valid_i;
  logic          img_ready_o;
  logic [31:0]   img_addr_i;
  logic [127:0]  img_data_i;
  logic          img_last_i;
  logic          awvalid_o;
  logic          awready_i;
  logic [31:0]   awaddr_o;
  logic [5:0]    awid_o;
  logic [7:0]    awlen_o;
  logic [2:0]    awsize_o;
  logic [1:0]    awburst_o;
  logic          wvalid_o;
  logic          wready_i;
  logic [127:0]  wdata_o;
  logic [15:0]   wstrb_o;
  logic          wlast_o;
  logic          bvalid_i;
  logic          bready_o;
  logic [1:0]    bresp_i;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic [31:0]   word_cnt_o;

  always #5 clk = ~clk;

  e_core_boot_loader #(
    .ADDR_W  (32),
    .DATA_W  (128),
    .ID_W    (6),
    .CSR_BASE(32'h0003_0000),
    .TMO_CYC (16)
  ) dut (
    .io_aclk    (clk),
    .io_aresetn (aresetn),
    .start_i    (start_i),
    .start_pc_i (start_pc_i),
    .img_valid_i(img_valid_i),
    .img_ready_o(img_ready_o),
    .img_addr_i (img_addr_i),
    .img_data_i (img_data_i),
    .img_last_i (img_last_i),
    .awvalid_o  (awvalid_o),
    .awready_i  (awready_i),
    .awaddr_o   (awaddr_o),
    .awid_o     (awid_o),
    .awlen_o    (awlen_o),
    .awsize_o   (awsize_o),
    .awburst_o  (awburst_o),
    .wvalid_o   (wvalid_o),
    .wready_i   (wready_i),
    .wdata_o    (wdata_o),
    .wstrb_o    (wstrb_o),
    .wlast_o    (wlast_o),
    .bvalid_i   (bvalid_i),
    .bready_o   (bready_o),
    .bresp_i    (bresp_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .word_cnt_o (word_cnt_o)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic         first;
    logic [31:0]  pc;
    logic [31:0]  addr;
    logic [127:0] data;
    logic         last;
    int           aw_dly;
    int           w_dly;
    logic [31:0]  exp_addr;
    logic [31:0]  exp_cnt;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] pc);
    start_i    = 1'b1;
    start_pc_i = pc;
    step();
    start_i    = 1'b0;
    start_pc_i = 32'hFFFF_FFFF;
  endtask

  task automatic feed(input logic [31:0] addr, input logic [127:0] data, input logic last);
    chk("img_ready_in_load", img_ready_o, 1'b1);
    img_valid_i = 1'b1;
    img_addr_i  = addr;
    img_data_i  = data;
    img_last_i  = last;
    step();
    img_valid_i = 1'b0;
    img_last_i  = 1'b0;
    img_data_i  = '0;
    chk("img_ready_single_cycle", img_ready_o, 1'b0);
  endtask

  // Slave side of one write: delays AW/W readies, checks hold-stability, answers B.
  task automatic slave_write(input int aw_dly, input int w_dly, input logic [1:0] resp,
                             output logic [31:0] a, output logic [127:0] d,
                             output logic [15:0] s, output int lat);
    int   cyc;
    bit   awd;
    bit   wd;
    logic ar;
    logic wr;
    lat = 0;
    while (!awvalid_o && lat < 64) begin
      step();
      lat++;
    end
    chk("aw_w_valid_together", {awvalid_o, wvalid_o}, 2'b11);
    chk("aw_attrs", {awid_o, awlen_o, awsize_o, awburst_o, wlast_o},
        {6'd0, 8'd0, 3'd4, 2'b01, 1'b1});
    a = awaddr_o;
    d = wdata_o;
    s = wstrb_o;
    awd = 1'b0;
    wd  = 1'b0;
    cyc = 0;
    while (!(awd && wd) && cyc < 64) begin
      awready_i = !awd && (cyc >= aw_dly);
      wready_i  = !wd && (cyc >= w_dly);
      if (!awd) begin
        chk("aw_hold_valid", awvalid_o, 1'b1);
        chk("aw_hold_addr", awaddr_o, a);
      end else begin
        chk("aw_dropped", awvalid_o, 1'b0);
      end
      if (!wd) begin
        chk("w_hold_valid", wvalid_o, 1'b1);
        chk("w_hold_data", wdata_o, d);
        chk("w_hold_strb", wstrb_o, s);
      end else begin
        chk("w_dropped", wvalid_o, 1'b0);
      end
      ar = awready_i;
      wr = wready_i;
      step();
      if (ar) awd = 1'b1;
      if (wr) wd  = 1'b1;
      cyc++;
    end
    awready_i = 1'b0;
    wready_i  = 1'b0;
    chk("b_phase_entered", {awvalid_o, wvalid_o, bready_o}, 3'b001);
    bvalid_i = 1'b1;
    bresp_i  = resp;
    step();
    bvalid_i = 1'b0;
    bresp_i  = 2'b00;
  endtask

  task automatic csr_writes(input logic [31:0] pc);
    logic [31:0]  a;
    logic [127:0] d;
    logic [15:0]  s;
    int           lat;
    slave_write(0, 0, 2'b00, a, d, s, lat);
    chk("pc_awaddr", a, 32'h0003_0004);
    chk("pc_wdata", d, {64'd0, pc, 32'd0});
    chk("pc_wstrb", s, 16'h00F0);
    chk("pc_not_done_yet", done_o, 1'b0);
    slave_write(0, 0, 2'b00, a, d, s, lat);
    chk("ctrl_awaddr", a, 32'h0003_0000);
    chk("ctrl_wdata", d, 128'd1);
    chk("ctrl_wstrb", s, 16'h000F);
    chk("done_after_ctrl", {done_o, busy_o, err_o}, 3'b100);
  endtask

  logic [31:0]  ra;
  logic [127:0] rd;
  logic [15:0]  rs;
  int           rlat;

  initial begin
    tbl[0] = '{1'b1, 32'h0000_8000, 32'h000, 128'hA0A0_0000_1111_2222_3333_4444_5555_6666, 1'b0, 0, 0, 32'h000, 32'd1};
    tbl[1] = '{1'b0, 32'h0000_8000, 32'h010, 128'hA1A1_0001_0002_0003_0004_0005_0006_0007, 1'b0, 0, 0, 32'h010, 32'd2};
    tbl[2] = '{1'b0, 32'h0000_8000, 32'h020, 128'hA2A2_DEAD_BEEF_0000_0000_0000_0000_0001, 1'b0, 0, 0, 32'h020, 32'd3};
    tbl[3] = '{1'b0, 32'h0000_8000, 32'h030, 128'hA3A3_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b1, 0, 0, 32'h030, 32'd4};
    tbl[4] = '{1'b1, 32'h1234_5678, 32'h105, 128'hB0B0_0123_4567_89AB_CDEF_0011_2233_4455, 1'b0, 5, 0, 32'h100, 32'd1};
    tbl[5] = '{1'b0, 32'h1234_5678, 32'h20F, 128'hB1B1_8899_AABB_CCDD_EEFF_0000_1111_2222, 1'b1, 0, 5, 32'h200, 32'd2};

    aresetn     = 1'b0;
    start_i     = 1'b0;
    start_pc_i  = '0;
    img_valid_i = 1'b0;
    img_addr_i  = '0;
    img_data_i  = '0;
    img_last_i  = 1'b0;
    awready_i   = 1'b0;
    wready_i    = 1'b0;
    bvalid_i    = 1'b0;
    bresp_i     = 2'b00;
    repeat (3) step();

    chk("reset_valids", {awvalid_o, wvalid_o, bready_o, img_ready_o}, 4'b0000);
    chk("reset_flags", {busy_o, done_o, err_o}, 3'b000);
    chk("reset_word_cnt", word_cnt_o, 32'd0);
    aresetn = 1'b1;
    step();
    chk("idle_no_ready", img_ready_o, 1'b0);

    // Image boots from the table; CSR writes follow each last word.
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].first) begin
        do_start(tbl[i].pc);
        chk("start_clears", {busy_o, done_o, err_o}, 3'b100);
        chk("start_cnt_zero", word_cnt_o, 32'd0);
      end
      feed(tbl[i].addr, tbl[i].data, tbl[i].last);
      slave_write(tbl[i].aw_dly, tbl[i].w_dly, 2'b00, ra, rd, rs, rlat);
      chk("img_aw_latency", rlat, 0);
      chk("img_awaddr", ra, tbl[i].exp_addr);
      chk("img_wdata", rd, tbl[i].data);
      chk("img_wstrb", rs, 16'hFFFF);
      chk("img_word_cnt", word_cnt_o, tbl[i].exp_cnt);
      if (tbl[i].last) csr_writes(tbl[i].pc);
      else chk("img_back_to_load", img_ready_o, 1'b1);
    end

    // SLVERR on second image word: error, no CSR writes, restart recovers.
    do_start(32'h0000_0100);
    feed(32'h000, 128'hC0, 1'b0);
    slave_write(0, 0, 2'b00, ra, rd, rs, rlat);
    feed(32'h010, 128'hC1, 1'b0);
    slave_write(0, 0, 2'b10, ra, rd, rs, rlat);
    chk("slverr_flags", {busy_o, done_o, err_o}, 3'b001);
    chk("slverr_word_cnt", word_cnt_o, 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk("no_csr_after_err", {awvalid_o, wvalid_o, img_ready_o}, 3'b000);
      step();
    end
    do_start(32'h0000_0200);
    chk("restart_clears_err", {busy_o, err_o, img_ready_o}, 3'b101);
    chk("restart_cnt_zero", word_cnt_o, 32'd0);
    feed(32'h040, 128'hC2, 1'b1);
    slave_write(0, 0, 2'b00, ra, rd, rs, rlat);
    chk("restart_awaddr", ra, 32'h040);
    chk("restart_cnt", word_cnt_o, 32'd1);
    csr_writes(32'h0000_0200);

    // start_i in LOAD ignored; single word carrying img_last.
    do_start(32'h0000_0040);
    start_i    = 1'b1;
    start_pc_i = 32'h0000_DEAD;
    step();
    start_i    = 1'b0;
    chk("start_in_load_ignored", {busy_o, img_ready_o}, 2'b11);
    feed(32'h080, 128'hD0, 1'b1);
    slave_write(0, 0, 2'b00, ra, rd, rs, rlat);
    chk("single_awaddr", ra, 32'h080);
    chk("single_cnt", word_cnt_o, 32'd1);
    csr_writes(32'h0000_0040);

    // Reset while waiting for B.
    do_start(32'h0000_0300);
    feed(32'h000, 128'hE0, 1'b0);
    slave_write(0, 0, 2'b00, ra, rd, rs, rlat);
    feed(32'h010, 128'hE1, 1'b0);
    chk("pre_reset_aw", awvalid_o, 1'b1);
    awready_i = 1'b1;
    wready_i  = 1'b1;
    step();
    awready_i = 1'b0;
    wready_i  = 1'b0;
    chk("pre_reset_wait_b", bready_o, 1'b1);
    aresetn = 1'b0;
    step();
    chk("midreset_valids", {awvalid_o, wvalid_o, bready_o, img_ready_o}, 4'b0000);
    chk("midreset_flags", {busy_o, done_o, err_o}, 3'b000);
    chk("midreset_cnt", word_cnt_o, 32'd0);
    aresetn = 1'b1;
    step();
    chk("post_reset_idle", {img_ready_o, busy_o}, 2'b00);
    do_start(32'h0000_0400);
    feed(32'h000, 128'hE2, 1'b1);
    slave_write(0, 0, 2'b00, ra, rd, rs, rlat);
    csr_writes(32'h0000_0400);

    // B never arrives.
    do_start(32'h0000_0500);
    feed(32'h000, 128'hF0, 1'b0);
    awready_i = 1'b1;
    wready_i  = 1'b1;
    step();
    awready_i = 1'b0;
    wready_i  = 1'b0;
    chk("tmo_wait_b", bready_o, 1'b1);
`ifdef E_CORE_BOOT_TIMEOUT_EN
    repeat (15) step();
    chk("tmo_not_yet", {bready_o, err_o}, 2'b10);
    step();
    chk("tmo_fired", {bready_o, err_o, busy_o}, 3'b010);
    chk("tmo_cnt", word_cnt_o, 32'd0);
`else
    repeat (40) step();
    chk("no_tmo_still_waiting", {bready_o, err_o, busy_o}, 3'b101);
    bvalid_i = 1'b1;
    step();
    bvalid_i = 1'b0;
    chk("no_tmo_b_accepted", {img_ready_o, word_cnt_o}, {1'b1, 32'd1});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
